// File: rtl/cmp_iter_pkg.sv
// Shared types and sizing helpers for the chunk-serial comparator.
package cmp_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of CHUNK-bit slices needed to cover WIDTH bits.
    function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Width of a counter that must hold values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Width of an index over 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk_eqge.sv
// Combinational unsigned compare of one chunk pair.
module cmp_chunk_eqge #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt
);

    // Equality and strict greater-than of the two chunks.
    always_comb begin
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/cmp_eqge_iter.sv
// Iterative chunk-serial equality / magnitude comparator, MSB chunk first,
// with valid/ready handshakes on operand and result sides.
module cmp_eqge_iter
    import cmp_iter_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned CHUNK  = 8,
    localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK),
    localparam int unsigned CW     = cnt_width(NCHUNK)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             eq_o,
    output logic             ge_o,
    output logic             gt_o,
    output logic [CW-1:0]    cycles_o
);

    localparam int unsigned    PW      = NCHUNK * CHUNK;
    localparam int unsigned    IW      = idx_width(NCHUNK);
    localparam logic [IW-1:0]  IDX_TOP = IW'(NCHUNK - 1);

    state_e            state;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     a_q;
    logic [PW-1:0]     b_q;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic              eq_q;
    logic              ge_q;
    logic [CW-1:0]     cycles_q;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic              chunk_eq;
    logic              chunk_gt;

    // Zero-extend to a whole number of chunks; for signed compares flip the
    // sign bits so two's-complement order becomes plain unsigned order.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[WIDTH-1:0] = a_i;
        b_ext[WIDTH-1:0] = b_i;
        if (signed_i) begin
            a_ext[WIDTH-1] = ~a_i[WIDTH-1];
            b_ext[WIDTH-1] = ~b_i[WIDTH-1];
        end
    end

    // Select the chunk pair currently under examination.
    always_comb begin
        a_chunk = a_q[idx*CHUNK +: CHUNK];
        b_chunk = b_q[idx*CHUNK +: CHUNK];
        cnt_inc = cnt + CW'(1);
    end

    cmp_chunk_eqge #(
        .W (CHUNK)
    ) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .eq (chunk_eq),
        .gt (chunk_gt)
    );

    // Control FSM: latch operands, walk chunks MSB-first, hold the result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            cnt      <= '0;
            eq_q     <= 1'b0;
            ge_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q   <= a_ext;
                        b_q   <= b_ext;
                        idx   <= IDX_TOP;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt_inc;
                    if (!chunk_eq) begin
                        eq_q     <= 1'b0;
                        ge_q     <= chunk_gt;
                        cycles_q <= cnt_inc;
                        state    <= DONE;
                    end else if (idx == '0) begin
                        eq_q     <= 1'b1;
                        ge_q     <= 1'b1;
                        cycles_q <= cnt_inc;
                        state    <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags follow the state; results come from held registers.
    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = (state == DONE);
        eq_o        = eq_q;
        ge_o        = ge_q;
        gt_o        = ge_q & ~eq_q;
        cycles_o    = cycles_q;
    end

endmodule

// File: tb/tb_cmp_eqge_iter.sv
// Scoreboard bench for cmp_eqge_iter: a 16/4 instance and a ragged 10/4 instance.
module tb_cmp_eqge_iter;

    typedef struct {
        logic [5:0] res;   // {eq, ge, gt, cycles[2:0]}
        int         lat;   // cycles from acceptance cycle (inclusive) to first valid cycle
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v16, r16, ov16, or16, eq16, ge16, gt16, s16;
    logic [15:0] a16, b16;
    logic [2:0]  cyc16;

    logic        v10, r10, ov10, or10, eq10, ge10, gt10, s10;
    logic [9:0]  a10, b10;
    logic [1:0]  cyc10;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    cmp_eqge_iter #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v16), .in_ready_o(r16),
        .a_i(a16), .b_i(b16), .signed_i(s16), .out_valid_o(ov16), .out_ready_i(or16),
        .eq_o(eq16), .ge_o(ge16), .gt_o(gt16), .cycles_o(cyc16)
    );

    cmp_eqge_iter #(.WIDTH(10), .CHUNK(4)) dut10 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v10), .in_ready_o(r10),
        .a_i(a10), .b_i(b10), .signed_i(s10), .out_valid_o(ov10), .out_ready_i(or10),
        .eq_o(eq10), .ge_o(ge10), .gt_o(gt10), .cycles_o(cyc10)
    );

    function automatic logic rdy(input int w);
        return (w == 16) ? r16 : r10;
    endfunction

    function automatic logic ovld(input int w);
        return (w == 16) ? ov16 : ov10;
    endfunction

    function automatic logic [5:0] res(input int w);
        if (w == 16) return {eq16, ge16, gt16, cyc16};
        return {eq10, ge10, gt10, 1'b0, cyc10};
    endfunction

    task automatic set_in(input int w, input logic v, input logic [15:0] a, input logic [15:0] b, input logic s);
        if (w == 16) begin
            v16 = v; a16 = a; b16 = b; s16 = s;
        end else begin
            v10 = v; a10 = a[9:0]; b10 = b[9:0]; s10 = s;
        end
    endtask

    task automatic set_ordy(input int w, input logic r);
        if (w == 16) or16 = r;
        else         or10 = r;
    endtask

    // Reference model built from integer arithmetic and the highest differing bit.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        int   mask, ua, ub, sa, sb_, nch, k, x;
        logic eq, ge, gt;
        mask = (1 << w) - 1;
        ua   = int'(a) & mask;
        ub   = int'(b) & mask;
        sa   = ua;
        sb_  = ub;
        if (s && ((ua >> (w - 1)) & 1) == 1) sa = ua - (1 << w);
        if (s && ((ub >> (w - 1)) & 1) == 1) sb_ = ub - (1 << w);
        eq  = (ua == ub);
        ge  = s ? (sa >= sb_) : (ua >= ub);
        gt  = ge && !eq;
        nch = (w + 3) / 4;
        k   = nch;
        x   = ua ^ ub;
        for (int p = w - 1; p >= 0; p--) begin
            if (((x >> p) & 1) == 1) begin
                k = nch - p / 4;
                break;
            end
        end
        e.res = {eq, ge, gt, 3'(k)};
        e.lat = k + 1;
        return e;
    endfunction

    task automatic push_exp(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
        sb.push_back(model(w, a, b, s));
    endtask

    // Present operands, wait for acceptance, then scramble the inputs.
    task automatic accept(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
        bit ok = 1'b0;
        @(negedge clk);
        set_in(w, 1'b1, a, b, s);
        for (int i = 0; i < 50; i++) begin
            if (rdy(w)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL accept_timeout dut%0d: in_ready_o=0, required 1", w);
            n_fail++;
        end
        @(posedge clk);
        #1;
        set_in(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        push_exp(w, a, b, s);
    endtask

    // Wait for a result, compare to the scoreboard, optionally hold it under backpressure
    // while a new operand set is already being offered.
    task automatic collect(input int w, input int hold, input bit pend,
                           input logic [15:0] pa, input logic [15:0] pb, input logic ps);
        exp_t       e;
        int         lat;
        bit         got;
        logic [5:0] first;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty dut%0d: size=0, required >0", w);
            return;
        end
        e   = sb.pop_front();
        lat = 1;
        got = 1'b0;
        set_ordy(w, hold == 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ovld(w)) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            $display("FAIL result_timeout dut%0d: out_valid_o=0, required 1", w);
            n_fail++;
            set_ordy(w, 1'b1);
            return;
        end
        n_checks++;
        if (lat !== e.lat) begin
            $display("FAIL latency dut%0d: got %0d, required %0d", w, lat, e.lat);
            n_fail++;
        end
        n_checks++;
        if (res(w) !== e.res) begin
            $display("FAIL result dut%0d: {eq,ge,gt,cyc}=%b, required %b", w, res(w), e.res);
            n_fail++;
        end
        first = res(w);
        if (pend) set_in(w, 1'b1, pa, pb, ps);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ovld(w) !== 1'b1 || rdy(w) !== 1'b0 || res(w) !== first) begin
                $display("FAIL hold dut%0d cyc%0d: valid=%b ready=%b res=%b, required 1 0 %b",
                         w, i, ovld(w), rdy(w), res(w), first);
                n_fail++;
            end
        end
        set_ordy(w, 1'b1);
        @(posedge clk);
        #1;
        n_checks++;
        if (ovld(w) !== 1'b0 || rdy(w) !== 1'b1) begin
            $display("FAIL release dut%0d: valid=%b ready=%b, required 0 1", w, ovld(w), rdy(w));
            n_fail++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (r16 !== 1'b1 || ov16 !== 1'b0 || res(16) !== 6'b0) begin
            $display("FAIL reset16: ready=%b valid=%b res=%b, required 1 0 000000", r16, ov16, res(16));
            n_fail++;
        end
        n_checks++;
        if (r10 !== 1'b1 || ov10 !== 1'b0 || res(10) !== 6'b0) begin
            $display("FAIL reset10: ready=%b valid=%b res=%b, required 1 0 000000", r10, ov10, res(10));
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_equal;
        accept(16, 16'h1234, 16'h1234, 1'b0);
        collect(16, 0, 1'b0, '0, '0, 1'b0);
        accept(16, 16'h0000, 16'h0000, 1'b1);
        collect(16, 0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_early_exit;
        accept(16, 16'h8000, 16'h7FFF, 1'b0);
        collect(16, 0, 1'b0, '0, '0, 1'b0);
        accept(16, 16'h8000, 16'h7FFF, 1'b1);
        collect(16, 0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_lsb_chunk;
        accept(16, 16'h1233, 16'h1234, 1'b0);
        collect(16, 0, 1'b0, '0, '0, 1'b0);
        accept(16, 16'hFFFF, 16'hFFFE, 1'b1);
        collect(16, 0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_random;
        logic [15:0] masks [5];
        logic [15:0] a, b, m;
        masks = '{16'h0000, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        for (int i = 0; i < 14; i++) begin
            a = 16'($urandom);
            m = masks[$urandom_range(0, 4)];
            b = (a & ~m) | (16'($urandom) & m);
            accept(16, a, b, 1'($urandom_range(0, 1)));
            collect(16, 0, 1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_backpressure;
        accept(16, 16'h4000, 16'h4001, 1'b0);
        collect(16, 6, 1'b1, 16'hA5A5, 16'h5A5A, 1'b1);
        @(posedge clk);
        #1;
        set_in(16, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
        push_exp(16, 16'hA5A5, 16'h5A5A, 1'b1);
        collect(16, 0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_ragged;
        accept(10, 16'h0200, 16'h01FF, 1'b1);
        collect(10, 0, 1'b0, '0, '0, 1'b0);
        accept(10, 16'h03FF, 16'h03FF, 1'b0);
        collect(10, 0, 1'b0, '0, '0, 1'b0);
        accept(10, 16'h0200, 16'h01FF, 1'b0);
        collect(10, 0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            accept(10, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            collect(10, 1, 1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_reset_midrun;
        accept(16, 16'h1233, 16'h1234, 1'b0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (ov16 !== 1'b0 || r16 !== 1'b1 || res(16) !== 6'b0) begin
            $display("FAIL midrun_reset: valid=%b ready=%b res=%b, required 0 1 000000", ov16, r16, res(16));
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ov16 !== 1'b0) begin
                $display("FAIL aborted_valid cyc%0d: out_valid_o=%b, required 0", i, ov16);
                n_fail++;
            end
        end
        accept(16, 16'h7FFF, 16'h8000, 1'b1);
        collect(16, 0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] ops [4];
        ops = '{16'hFFFF, 16'h0001, 16'h8001, 16'h7FF0};
        for (int i = 0; i < 4; i++) begin
            accept(16, ops[i], ops[(i + 1) % 4], 1'(i % 2));
            collect(16, 0, 1'b0, '0, '0, 1'b0);
        end
    endtask

    initial begin
        set_in(16, 1'b0, '0, '0, 1'b0);
        set_in(10, 1'b0, '0, '0, 1'b0);
        or16 = 1'b1;
        or10 = 1'b1;
        test_reset();
        test_equal();
        test_early_exit();
        test_lsb_chunk();
        test_random();
        test_backpressure();
        test_ragged();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
